// File: rtl/bfu_pipe_if.sv
// Bus bundle for bfu_pipe: an input channel (operands, mode, tag) and an
// output channel (two results, tag), each with its own valid/ready pair.
interface bfu_pipe_if #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            mode;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [DATA_WIDTH-1:0] tw_factor;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] mod_add_out;
   logic [DATA_WIDTH-1:0] mod_sub_out;
   logic [TAG_WIDTH-1:0]  tag_out;

   // Producer of transactions / consumer of results.
   modport master (
      output in_valid, mode, a, b, tw_factor, tag_in, out_ready,
      input  in_ready, out_valid, mod_add_out, mod_sub_out, tag_out
   );

   // The butterfly itself.
   modport slave (
      input  in_valid, mode, a, b, tw_factor, tag_in, out_ready,
      output in_ready, out_valid, mod_add_out, mod_sub_out, tag_out
   );
endinterface

// File: rtl/bfu_pipe.sv
// Pipelined modular butterfly (CT / GS / bypass) for the NTT/INTT datapath.
//
// Handshake: a transaction moves on a rising edge when valid && ready on that
// channel. The whole pipe advances together (adv = !out_valid || out_ready);
// in_ready mirrors adv, and when adv is low every stage, valid bits included,
// holds, so results stay stable until the consumer takes them. Bubbles travel
// with the pipe and are never squeezed out.
//
// Stage 1: register operands plus (a+b) mod q and (a-b) mod q.
// Stage 2: multiply the twiddle by b (CT) or by (a-b) mod q (GS).
// Stage 3: Barrett-reduce the product and form the final pair.
// Stages 4..LATENCY: pure retiming of the result pair.
module bfu_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int MODULO     = 7681,
   parameter int TAG_WIDTH  = 8,
   parameter int LATENCY    = 4
) (
   input  logic      clk,
   input  logic      rst,
   bfu_pipe_if.slave bus
);

   // Result stages: index 0 is stage 3, index NR-1 drives the outputs.
   localparam int NR = LATENCY - 2;

   localparam logic [1:0] MODE_CT = 2'b00;
   localparam logic [1:0] MODE_GS = 2'b01;

   localparam logic [DATA_WIDTH:0]   Q_N = (DATA_WIDTH+1)'(MODULO);
   localparam logic [2*DATA_WIDTH:0] Q_W = (2*DATA_WIDTH+1)'(MODULO);
   // Barrett constant floor(2^(2*DATA_WIDTH) / q). Any product is below
   // 2^(2*DATA_WIDTH), so the quotient estimate is short by at most one and a
   // single subtraction of q finishes the reduction.
   localparam logic [2*DATA_WIDTH:0] MU =
      {1'b1, {(2*DATA_WIDTH){1'b0}}} / Q_W;

   // (x + y) mod q for x, y < q, carried in DATA_WIDTH+1 bits.
   function automatic logic [DATA_WIDTH-1:0] mod_add(
      input logic [DATA_WIDTH-1:0] x,
      input logic [DATA_WIDTH-1:0] y
   );
      logic [DATA_WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q_N) s = s - Q_N;
      return DATA_WIDTH'(s);
   endfunction

   // (x - y) mod q for x, y < q; equal operands give 0, never q.
   function automatic logic [DATA_WIDTH-1:0] mod_sub(
      input logic [DATA_WIDTH-1:0] x,
      input logic [DATA_WIDTH-1:0] y
   );
      logic [DATA_WIDTH:0] d;
      d = {1'b0, x} - {1'b0, y};
      if (x < y) d = d + Q_N;
      return DATA_WIDTH'(d);
   endfunction

   // Stage 1 registers
   logic                  s1_v_q;
   logic [1:0]            s1_mode_q;
   logic [TAG_WIDTH-1:0]  s1_tag_q;
   logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q, s1_w_q, s1_sum_q, s1_dif_q;
   // Stage 2 registers
   logic                    s2_v_q;
   logic [1:0]              s2_mode_q;
   logic [TAG_WIDTH-1:0]    s2_tag_q;
   logic [DATA_WIDTH-1:0]   s2_a_q, s2_b_q, s2_sum_q;
   logic [2*DATA_WIDTH-1:0] s2_p_q;
   // Result stages
   logic                  rt_v_q   [NR];
   logic [DATA_WIDTH-1:0] rt_add_q [NR];
   logic [DATA_WIDTH-1:0] rt_sub_q [NR];
   logic [TAG_WIDTH-1:0]  rt_tag_q [NR];

   logic adv;

   assign adv          = !rt_v_q[NR-1] || bus.out_ready;
   // Reset wins over everything, so advertising ready while it is held is harmless.
   assign bus.in_ready = adv || rst;

   assign bus.out_valid   = rt_v_q[NR-1];
   assign bus.mod_add_out = rt_add_q[NR-1];
   assign bus.mod_sub_out = rt_sub_q[NR-1];
   assign bus.tag_out     = rt_tag_q[NR-1];

   // Stage 1 combinational: both add and subtract of the raw operands.
   logic [DATA_WIDTH-1:0] s1_sum_d, s1_dif_d;
   assign s1_sum_d = mod_add(bus.a, bus.b);
   assign s1_dif_d = mod_sub(bus.a, bus.b);

   // Stage 2 combinational: full-width product, no truncation.
   logic [DATA_WIDTH-1:0]   s2_x_d;
   logic [2*DATA_WIDTH-1:0] s2_p_d;
   assign s2_x_d = (s1_mode_q == MODE_GS) ? s1_dif_q : s1_b_q;
   assign s2_p_d = {{DATA_WIDTH{1'b0}}, s2_x_d} * {{DATA_WIDTH{1'b0}}, s1_w_q};

   // Stage 3 combinational: Barrett reduction, then per-mode result pair.
   logic [4*DATA_WIDTH:0] s3_bprod;
   logic [2*DATA_WIDTH:0] s3_qhat, s3_rem0, s3_rem1;
   logic [DATA_WIDTH-1:0] s3_r, s3_add_d, s3_sub_d;

   // Reduce the stage-2 product and pick the outputs for this transaction's mode.
   always_comb begin
      s3_bprod = {{(2*DATA_WIDTH+1){1'b0}}, s2_p_q} * {{(2*DATA_WIDTH){1'b0}}, MU};
      s3_qhat  = (2*DATA_WIDTH+1)'(s3_bprod >> (2*DATA_WIDTH));
      s3_rem0  = {1'b0, s2_p_q} - s3_qhat * Q_W;
      s3_rem1  = (s3_rem0 >= Q_W) ? s3_rem0 - Q_W : s3_rem0;
      s3_r     = DATA_WIDTH'(s3_rem1);
      case (s2_mode_q)
         MODE_CT: begin
            s3_add_d = mod_add(s2_a_q, s3_r);
            s3_sub_d = mod_sub(s2_a_q, s3_r);
         end
         MODE_GS: begin
            s3_add_d = s2_sum_q;
            s3_sub_d = s3_r;
         end
         default: begin
            s3_add_d = s2_a_q;
            s3_sub_d = s2_b_q;
         end
      endcase
   end

   // Stage 1: capture an accepted transaction; data only loads behind a valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_mode_q <= '0;
         s1_tag_q  <= '0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_w_q    <= '0;
         s1_sum_q  <= '0;
         s1_dif_q  <= '0;
      end else if (adv) begin
         s1_v_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode_q <= bus.mode;
            s1_tag_q  <= bus.tag_in;
            s1_a_q    <= bus.a;
            s1_b_q    <= bus.b;
            s1_w_q    <= bus.tw_factor;
            s1_sum_q  <= s1_sum_d;
            s1_dif_q  <= s1_dif_d;
         end
      end
   end

   // Stage 2: register the product alongside the operands still needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v_q    <= 1'b0;
         s2_mode_q <= '0;
         s2_tag_q  <= '0;
         s2_a_q    <= '0;
         s2_b_q    <= '0;
         s2_sum_q  <= '0;
         s2_p_q    <= '0;
      end else if (adv) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_mode_q <= s1_mode_q;
            s2_tag_q  <= s1_tag_q;
            s2_a_q    <= s1_a_q;
            s2_b_q    <= s1_b_q;
            s2_sum_q  <= s1_sum_q;
            s2_p_q    <= s2_p_d;
         end
      end
   end

   // Stage 3 and retiming stages: finished results shift toward the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            rt_v_q[i]   <= 1'b0;
            rt_add_q[i] <= '0;
            rt_sub_q[i] <= '0;
            rt_tag_q[i] <= '0;
         end
      end else if (adv) begin
         rt_v_q[0] <= s2_v_q;
         if (s2_v_q) begin
            rt_add_q[0] <= s3_add_d;
            rt_sub_q[0] <= s3_sub_d;
            rt_tag_q[0] <= s2_tag_q;
         end
         for (int i = 1; i < NR; i++) begin
            rt_v_q[i] <= rt_v_q[i-1];
            if (rt_v_q[i-1]) begin
               rt_add_q[i] <= rt_add_q[i-1];
               rt_sub_q[i] <= rt_sub_q[i-1];
               rt_tag_q[i] <= rt_tag_q[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_bfu_pipe.sv
// Self-checking bench for bfu_pipe: directed test-plan vectors, backpressure,
// a 1000-vector throughput run, random stalls/gaps and mid-stream reset,
// all scored against an arithmetic reference model.
module tb_bfu_pipe;

   localparam int DW  = 16;
   localparam int Q   = 7681;
   localparam int TW  = 8;
   localparam int LAT = 4;
   localparam int PW  = TW + 2*DW;

   localparam logic [1:0] M_CT  = 2'b00;
   localparam logic [1:0] M_GS  = 2'b01;
   localparam logic [1:0] M_BYP = 2'b10;
   localparam logic [1:0] M_RES = 2'b11;

   logic clk;
   logic rst;

   bfu_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   bfu_pipe #(
      .DATA_WIDTH(DW), .MODULO(Q), .TAG_WIDTH(TW), .LATENCY(LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish in time (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [PW-1:0] model(input logic [1:0] m, input longint unsigned av,
                                           input longint unsigned bv, input longint unsigned wv,
                                           input logic [TW-1:0] tg);
      longint unsigned q, t, x, y;
      q = Q;
      case (m)
         M_CT: begin
            t = (bv * wv) % q;
            x = (av + t) % q;
            y = (av + q - t) % q;
         end
         M_GS: begin
            x = (av + bv) % q;
            y = (((av + q - bv) % q) * wv) % q;
         end
         default: begin
            x = av;
            y = bv;
         end
      endcase
      return {tg, DW'(x), DW'(y)};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [PW-1:0] exp_q[$];
   int            acc_q[$];
   logic [PW-1:0] got_w, exp_w, snap;
   logic          prev_stall = 1'b0;
   logic          chk_lat    = 1'b1;
   logic          saw_ir_low = 1'b0;
   int            out_cnt = 0;
   int            n_spur  = 0;
   int            n_hold  = 0;
   int            last_lat = 0;
   int            acc_c;
   logic [DW-1:0] last_add, last_sub;
   logic [TW-1:0] last_tag;

   // Sample on the falling edge: these are the handshakes of the next rising edge.
   always @(negedge clk) begin
      got_w = {bus.tag_out, bus.mod_add_out, bus.mod_sub_out};
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_stall = 1'b0;
         check_eq("in_ready_during_rst", bus.in_ready, 1);
      end else begin
         if (prev_stall) begin
            n_hold++;
            check_eq("stall_hold", {bus.out_valid, got_w}, {1'b1, snap});
         end
         check_eq("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (!bus.in_ready) saw_ir_low = 1'b1;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_spur++;
            end else begin
               exp_w = exp_q.pop_front();
               acc_c = acc_q.pop_front();
               check_eq("result", got_w, exp_w);
               last_lat = cyc - acc_c;
               if (chk_lat) check_eq("latency", last_lat, LAT);
            end
            out_cnt++;
            last_tag = bus.tag_out;
            last_add = bus.mod_add_out;
            last_sub = bus.mod_sub_out;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.mode, bus.a, bus.b, bus.tw_factor, bus.tag_in));
            acc_q.push_back(cyc);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         snap       = got_w;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] m, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [DW-1:0] wv, input logic [TW-1:0] tg);
      logic acc;
      int   n;
      bus.in_valid  = 1'b1;
      bus.mode      = m;
      bus.a         = av;
      bus.b         = bv;
      bus.tw_factor = wv;
      bus.tag_in    = tg;
      n = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check_eq("send_accept_timeout", acc, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_one(input logic [1:0] m, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                          input logic [DW-1:0] wv, input logic [TW-1:0] tg);
      int base;
      int n;
      base = out_cnt;
      send(m, av, bv, wv, tg);
      n = 0;
      while (out_cnt == base && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("run_one_emitted", out_cnt - base, 1);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_out_valid"}, bus.out_valid, 0);
      check_eq({pfx, "_add"}, bus.mod_add_out, 0);
      check_eq({pfx, "_sub"}, bus.mod_sub_out, 0);
      check_eq({pfx, "_tag"}, bus.tag_out, 0);
      check_eq({pfx, "_in_ready"}, bus.in_ready, 1);
   endtask

   function automatic logic [DW-1:0] rnd_op();
      return DW'($urandom_range(0, Q-1));
   endfunction

   // ---------------- main sequence ----------------
   int   base_cnt, c0;
   logic rnd_done;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.mode      = M_CT;
      bus.a         = '0;
      bus.b         = '0;
      bus.tw_factor = '0;
      bus.tag_in    = '0;
      bus.out_ready = 1'b1;
      idle(2);
      check_reset_state("reset");
      rst = 1'b0;
      idle(2);

      // Directed test-plan vectors.
      run_one(M_CT, 16'd100, 16'd200, 16'd3, 8'h5A);
      check_eq("ct_add", last_add, 700);
      check_eq("ct_sub", last_sub, 7181);
      check_eq("ct_tag", last_tag, 8'h5A);
      check_eq("ct_latency", last_lat, LAT);
      run_one(M_GS, 16'd100, 16'd200, 16'd3, 8'h11);
      check_eq("gs_add", last_add, 300);
      check_eq("gs_sub", last_sub, 7381);
      run_one(M_BYP, 16'd123, 16'd456, 16'd999, 8'h22);
      check_eq("byp_add", last_add, 123);
      check_eq("byp_sub", last_sub, 456);
      run_one(M_RES, 16'd77, 16'd88, 16'd5, 8'h33);
      check_eq("res_add", last_add, 77);
      check_eq("res_sub", last_sub, 88);
      run_one(M_CT, 16'd7680, 16'd7680, 16'd7680, 8'h44);
      check_eq("max_add", last_add, 0);
      check_eq("max_sub", last_sub, 7679);
      run_one(M_CT, 16'd5, 16'd5, 16'd1, 8'h55);
      check_eq("zero_sub", last_sub, 0);
      check_eq("zero_sub_add", last_add, 10);

      // Backpressure: 8 tagged transactions, alternating modes, 5-cycle stall.
      chk_lat    = 1'b0;
      saw_ir_low = 1'b0;
      n_hold     = 0;
      base_cnt   = out_cnt;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send((i % 2 == 1) ? M_GS : M_CT, rnd_op(), rnd_op(), rnd_op(), TW'(i));
         end
         begin
            idle(5);
            bus.out_ready = 1'b0;
            idle(5);
            bus.out_ready = 1'b1;
         end
      join
      wait_drain(100);
      check_eq("bp_count", out_cnt - base_cnt, 8);
      check_eq("bp_in_ready_dropped", saw_ir_low, 1);
      check_eq("bp_held_cycles", n_hold, 5);
      check_eq("bp_last_tag", last_tag, 7);

      // Throughput: 1000 back-to-back CT/GS vectors with out_ready high.
      idle(2);
      chk_lat  = 1'b1;
      base_cnt = out_cnt;
      c0       = cyc;
      for (int i = 0; i < 1000; i++)
         send(($urandom_range(0, 1) == 1) ? M_GS : M_CT, rnd_op(), rnd_op(), rnd_op(), TW'(i));
      check_eq("tput_accept_cycles", cyc - c0, 1000);
      wait_drain(50);
      check_eq("tput_count", out_cnt - base_cnt, 1000);

      // Random modes, input gaps and random consumer stalls.
      chk_lat  = 1'b0;
      rnd_done = 1'b0;
      base_cnt = out_cnt;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
               send(2'($urandom_range(0, 3)), rnd_op(), rnd_op(), rnd_op(), TW'(i));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 2) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_drain(100);
      check_eq("rand_count", out_cnt - base_cnt, 300);

      // Mid-stream reset with 3 transactions in flight; rst beats in_valid.
      idle(2);
      chk_lat = 1'b1;
      send(M_CT, rnd_op(), rnd_op(), rnd_op(), 8'hA0);
      send(M_GS, rnd_op(), rnd_op(), rnd_op(), 8'hA1);
      send(M_CT, rnd_op(), rnd_op(), rnd_op(), 8'hA2);
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.mode      = M_CT;
      bus.a         = 16'd1;
      bus.b         = 16'd2;
      bus.tw_factor = 16'd3;
      bus.tag_in    = 8'hEE;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check_reset_state("mid_rst");
      base_cnt = out_cnt;
      idle(12);
      check_eq("no_stale_after_rst", out_cnt - base_cnt, 0);
      run_one(M_CT, 16'd100, 16'd200, 16'd3, 8'h77);
      check_eq("post_rst_latency", last_lat, LAT);
      check_eq("post_rst_add", last_add, 700);
      check_eq("post_rst_tag", last_tag, 8'h77);

      idle(4);
      check_eq("spurious_outputs", n_spur, 0);
      check_eq("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
